// File: rtl/breakout_pixel_renderer.sv
// Breakout pixel renderer: two-stage pipeline from VGA timing (row/col/syncs) to RGB,
// plus the brick-presence map with a vblank-gated clear handshake.
`default_nettype none

module breakout_pixel_renderer #(
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 64,
  parameter int PADDLE_Y  = 456,
  parameter int BRICK_TOP = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset_L,
  input  logic       HS,
  input  logic       VS,
  input  logic       blank,
  input  logic [8:0] row,
  input  logic [9:0] col,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [9:0] paddle_x,
  input  logic       new_game,
  input  logic       clr_valid,
  input  logic [4:0] clr_idx,
  output logic       clr_ready,
  output logic [5:0] bricks_left,
  output logic       frame_start,
  output logic       HS_out,
  output logic       VS_out,
  output logic       blank_out,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [10:0] BALL_SZ   = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W     = 11'(PADDLE_W);
  localparam logic [10:0] PAD_Y     = 11'(PADDLE_Y);
  localparam logic [10:0] WALL_TOP  = 11'(BRICK_TOP);
  localparam logic [5:0]  ALL_BRICKS = 6'd32;

  logic [31:0] brick_map;
  logic        vs_reg;
  logic        vblank;

  // All geometry is done at 11 bits so position + size can never wrap to column 0.
  logic [10:0] col_w, row_w, bx_w, by_w, px_w;
  assign col_w = {1'b0, col};
  assign row_w = {2'b00, row};
  assign bx_w  = {1'b0, ball_x};
  assign by_w  = {2'b00, ball_y};
  assign px_w  = {1'b0, paddle_x};

  logic ball_hit, paddle_hit, border_hit, in_wall, brick_hit;
  logic mortar_row, mortar_col;
  logic [5:0]  wall_rel;
  logic [1:0]  brick_row;
  logic [2:0]  brick_col;
  logic [10:0] col_base;
  logic [4:0]  brick_idx;

  assign ball_hit   = (col_w >= bx_w) && (col_w < bx_w + BALL_SZ) &&
                      (row_w >= by_w) && (row_w < by_w + BALL_SZ);
  assign paddle_hit = (col_w >= px_w) && (col_w < px_w + PAD_W) &&
                      (row_w >= PAD_Y) && (row_w < PAD_Y + 11'd8);
  assign border_hit = (col_w < 11'd8) || (col_w >= 11'd632) || (row_w < 11'd8);

  assign in_wall    = (row_w >= WALL_TOP) && (row_w < WALL_TOP + 11'd64);
  assign wall_rel   = 6'(row_w - WALL_TOP);
  assign brick_row  = wall_rel[5:4];
  assign mortar_row = (wall_rel[3:0] == 4'd0);

  // Column-to-brick mapping by comparator chain; col_base is the brick's left edge (mortar column).
  always_comb begin
    brick_col = 3'd0;
    col_base  = 11'd0;
    for (int k = 1; k < 8; k++) begin
      if (col_w >= 11'(k * 80)) begin
        brick_col = 3'(k);
        col_base  = 11'(k * 80);
      end
    end
  end

  assign mortar_col = (col_w == col_base);
  assign brick_idx  = {brick_row, brick_col};
  assign brick_hit  = in_wall && brick_map[brick_idx] && !mortar_row && !mortar_col;

  logic       ball_s1, paddle_s1, brick_s1, border_s1;
  logic [1:0] brick_row_s1;
  logic       hs_s1, vs_s1, blank_s1;

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      ball_s1      <= 1'b0;
      paddle_s1    <= 1'b0;
      brick_s1     <= 1'b0;
      border_s1    <= 1'b0;
      brick_row_s1 <= 2'd0;
      hs_s1        <= 1'b1;
      vs_s1        <= 1'b1;
      blank_s1     <= 1'b1;
    end else begin
      ball_s1      <= ball_hit;
      paddle_s1    <= paddle_hit;
      brick_s1     <= brick_hit;
      border_s1    <= border_hit;
      brick_row_s1 <= brick_row;
      hs_s1        <= HS;
      vs_s1        <= VS;
      blank_s1     <= blank;
    end
  end

  logic [23:0] pix_rgb;

  always_comb begin
    pix_rgb = 24'h000000;
    if (blank_s1) begin
      pix_rgb = 24'h000000;
    end else if (ball_s1) begin
      pix_rgb = 24'hFFFFFF;
    end else if (paddle_s1) begin
      pix_rgb = 24'h00C0FF;
    end else if (brick_s1) begin
      case (brick_row_s1)
        2'd0:    pix_rgb = 24'hFF0000;
        2'd1:    pix_rgb = 24'hFF8000;
        2'd2:    pix_rgb = 24'hFFFF00;
        default: pix_rgb = 24'h00FF00;
      endcase
    end else if (border_s1) begin
      pix_rgb = 24'h808080;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      HS_out    <= 1'b1;
      VS_out    <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      {red, green, blue} <= pix_rgb;
      HS_out    <= hs_s1;
      VS_out    <= vs_s1;
      blank_out <= blank_s1;
    end
  end

  // vs_reg resets low so a VS that is already low at reset release is not taken as a falling edge.
  assign frame_start = vs_reg && !VS;
  assign clr_ready   = vblank && !new_game;

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      vs_reg <= 1'b0;
      vblank <= 1'b0;
    end else begin
      vs_reg <= VS;
      if (frame_start) begin
        vblank <= 1'b1;
      end else if (!blank) begin
        vblank <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      brick_map   <= '1;
      bricks_left <= ALL_BRICKS;
    end else if (new_game) begin
      brick_map   <= '1;
      bricks_left <= ALL_BRICKS;
    end else if (clr_valid && clr_ready) begin
      brick_map[clr_idx] <= 1'b0;
      if (brick_map[clr_idx] && (bricks_left != 6'd0)) begin
        bricks_left <= bricks_left - 6'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/breakout_pixel_renderer.md
Name: breakout_pixel_renderer

Overview:
- Sits directly downstream of the VGA timing generator and consumes its HS, VS, blank, row and col outputs.
- Produces 24-bit RGB for the ball, the paddle, a 32-brick wall, the border and the background, with the sync signals delayed to match the pixel data.
- Owns the brick-presence map. Game logic clears bricks through a valid/ready handshake, which is accepted only during vertical blanking so the display never tears.

Parameters:
- BALL_SIZE, 8: ball square side in pixels.
- PADDLE_W, 64: paddle width in pixels.
- PADDLE_Y, 456: top row of the paddle; paddle height is fixed at 8.
- BRICK_TOP, 32: top row of the brick wall.

Ports:
- CLOCK_50 input 1: system clock, one pixel sample per cycle.
- reset_L input 1: asynchronous, active-low reset.
- HS input 1: horizontal sync from timing generator, low during pulse.
- VS input 1: vertical sync from timing generator, low during pulse.
- blank input 1: high when the pixel is not displayable.
- row input 9: display row 0..479, valid when blank=0.
- col input 10: display column 0..639, valid when blank=0.
- ball_x input 10: ball left column.
- ball_y input 9: ball top row.
- paddle_x input 10: paddle left column.
- new_game input 1: one-cycle pulse that refills all bricks.
- clr_valid input 1: brick-clear request.
- clr_idx input 5: brick index, computed as brick_row*8 + brick_col.
- clr_ready output 1: clear accepted when clr_valid && clr_ready.
- bricks_left output 6: number of bricks present, 0..32.
- frame_start output 1: one-cycle pulse on the falling edge of VS.
- HS_out output 1: HS delayed 2 cycles.
- VS_out output 1: VS delayed 2 cycles.
- blank_out output 1: blank delayed 2 cycles.
- red, green, blue output 8 each: pixel colour aligned with blank_out.

Behaviour:
- Reset (async, while reset_L=0):
  - brick map all 1s; bricks_left=32.
  - pipeline registers cleared: RGB=0, HS_out=1, VS_out=1, blank_out=1.
  - frame_start=0, vblank flag=0, clr_ready=0.
- Pipeline, fixed latency of 2 cycles for all of HS, VS, blank and RGB:
  - Stage 1 registers the hit flags (ball, paddle, brick, border), the brick row and the delayed syncs.
  - Stage 2 registers the priority-muxed RGB.
- Geometry (all compares in 11-bit unsigned, so x+size never wraps):
  - Ball: ball_x <= col < ball_x+BALL_SIZE and ball_y <= row < ball_y+BALL_SIZE.
  - Paddle: paddle_x <= col < paddle_x+PADDLE_W and PADDLE_Y <= row < PADDLE_Y+8.
  - Brick wall: rows BRICK_TOP..BRICK_TOP+63, arranged as 4 brick rows of 16 px by 8 brick columns of 80 px.
    - brick_row = (row-BRICK_TOP)/16; brick_col = col/80, implemented by comparator chain, no divider.
    - The pixel is a brick pixel only if map[idx]=1 and it is not on the 1-px mortar line ((row-BRICK_TOP)%16==0 or col%80==0).
  - Border: col<8, col>=632 or row<8.
- Colour priority, highest first:
  1. ball FFFFFF
  2. paddle 00C0FF
  3. brick, coloured by brick row: 0=FF0000, 1=FF8000, 2=FFFF00, 3=00FF00
  4. border 808080
  5. background 000000
- When the stage-2 blank is 1, the RGB output is 000000 regardless of hits.
- Objects partially off-screen draw only their visible part. No object wraps to column 0.
- Frame and vblank tracking:
  - frame_start = registered VS is 1 and VS is 0, for exactly 1 cycle per frame.
  - The vblank flag sets on the cycle after frame_start and clears on the first cycle with blank=0.
  - clr_ready = vblank flag && !new_game.
- Clear handshake:
  - On a cycle with clr_valid && clr_ready: map[clr_idx] <= 0, and bricks_left decrements only if map[clr_idx] was 1.
  - Clearing an already-clear brick is accepted as a no-op.
  - clr_valid with clr_ready=0 has no effect; the requester holds the request until ready.
  - At most one clear per cycle; a back-to-back clear of the same idx decrements once.
- new_game sets map to all 1s and bricks_left=32 on the next edge. It overrides a same-cycle clear, and clr_ready is low that cycle.
- bricks_left saturates at 0; it never underflows.
- A reset asserted mid-frame takes effect immediately. After release, frame_start is not asserted until the next true VS falling edge.

Test Plan:
- Reset, then drive row=100, col=100, blank=0 with the ball at (100,100) -> 2 cycles later RGB=FFFFFF. Drive blank=1 -> RGB=000000 after 2 cycles.
- Ball at (0,40) overlapping brick 0, which is present, at row 40 col 2 -> white. Move the ball away -> FF0000. On the mortar pixel row 48 col 2 -> background 000000 (col<8 is border, so use col 81: expect 000000 at row 48).
- During vblank (VS pulse then blank=1), clr_valid with clr_idx=9 -> accepted; bricks_left 32->31. Pixel row 50 col 90 -> background, not FF8000.
- clr_valid with idx=5 while blank=0 mid-frame -> clr_ready=0, map unchanged. Hold the request into the next vblank -> accepted exactly once, bricks_left=31.
- Clear idx 3 twice in vblank -> bricks_left drops by 1 only. Pulse new_game together with clr_valid -> bricks_left=32, clr_ready=0 that cycle.
- HS/VS toggle pattern -> HS_out/VS_out reproduce it exactly 2 cycles later. frame_start is one cycle per VS fall. Assert reset_L=0 mid-line -> outputs reach reset values immediately without waiting for a clock edge.
